// File: rtl/uart_program_loader.sv
// Serial boot loader: receives a framed program image over UART and writes
// 16-bit words into instruction memory from address 0, holding the core in reset.
module uart_program_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              load_en,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned   CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam int unsigned   CAP  = 1 << ADDR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [3:0] {
    IDLE, SYNC, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR
  } state_t;

  rx_state_t       rx_state;
  logic            rx_meta, rx_sync;
  logic [CW-1:0]   tick;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [7:0]      rx_byte;
  logic            byte_valid, frame_err;

  state_t          state;
  logic [7:0]      len_hi, data_hi, chk;
  logic [ADDR_W:0] len;
  logic            drop_hold;
  logic [15:0]     len_word;

  assign len_word = {len_hi, rx_byte};

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_state   <= RX_IDLE;
      tick       <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          tick <= '0;
          if (!rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (tick == HALF) begin
            tick     <= '0;
            bit_idx  <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        RX_DATA: begin
          if (tick == FULL) begin
            tick    <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        RX_STOP: begin
          if (tick == FULL) begin
            tick     <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              rx_byte    <= shift;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      mem_wren   <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
      len_hi     <= '0;
      data_hi    <= '0;
      chk        <= '0;
      len        <= '0;
      drop_hold  <= 1'b0;
    end else begin
      mem_wren  <= 1'b0;
      drop_hold <= 1'b0;
      // cpu_hold is released the cycle after done rises
      if (drop_hold) cpu_hold <= 1'b0;
      if (frame_err && (state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK})) begin
        state <= ERROR;
      end else begin
        case (state)
          IDLE: begin
            if (load_en) begin
              state      <= SYNC;
              done       <= 1'b0;
              err        <= 1'b0;
              word_count <= '0;
            end
          end
          SYNC: begin
            if (byte_valid && rx_byte == 8'hA5) begin
              state    <= LEN_HI;
              busy     <= 1'b1;
              cpu_hold <= 1'b1;
              chk      <= '0;
            end
          end
          LEN_HI: begin
            if (byte_valid) begin
              len_hi <= rx_byte;
              state  <= LEN_LO;
            end
          end
          LEN_LO: begin
            if (byte_valid) begin
              if (len_word == '0 || 32'(len_word) > CAP) begin
                state <= ERROR;
              end else begin
                len   <= (ADDR_W + 1)'(len_word);
                state <= DATA_HI;
              end
            end
          end
          DATA_HI: begin
            if (byte_valid) begin
              data_hi <= rx_byte;
              chk     <= chk ^ rx_byte;
              state   <= DATA_LO;
            end
          end
          DATA_LO: begin
            if (byte_valid) begin
              mem_wren   <= 1'b1;
              mem_addr   <= word_count[ADDR_W-1:0];
              mem_data   <= {data_hi, rx_byte};
              chk        <= chk ^ rx_byte;
              word_count <= word_count + 1'b1;
              state      <= ((word_count + 1'b1) == len) ? CHECK : DATA_HI;
            end
          end
          CHECK: begin
            if (byte_valid) state <= (rx_byte == chk) ? DONE : ERROR;
          end
          DONE: begin
            done      <= 1'b1;
            busy      <= 1'b0;
            drop_hold <= 1'b1;
            state     <= IDLE;
          end
          ERROR: begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
